// File: rtl/flash_mirror_sequencer_if.sv
// Host request/response and SPI pin bundle for the mirrored flash sequencer.
// The slave side is the sequencer itself. The master side is the host plus the flash pins it faces.
interface flash_mirror_sequencer_if #(
  parameter int ADDR_W = 24
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic [1:0]        disk_fail;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              spi_sck;
  logic              spi_mosi;
  logic [1:0]        spi_cs_n;
  logic [1:0]        spi_miso;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, disk_fail, spi_miso,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy, spi_sck, spi_mosi, spi_cs_n
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, disk_fail, spi_miso,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy, spi_sck, spi_mosi, spi_cs_n
  );
endinterface

// File: rtl/flash_mirror_sequencer.sv
// SPI NOR command sequencer for a RAID-1 pair of flash chips.
// Writes fan out to every healthy chip (WREN, PAGE PROGRAM, RDSR polling).
// Reads come from chip 0, or from chip 1 when chip 0 is marked failed.
module flash_mirror_sequencer #(
  parameter int ADDR_W   = 24,
  parameter int CS_GAP   = 2,
  parameter int POLL_MAX = 1023
) (
  input logic                    clk,
  input logic                    rst_n,
  flash_mirror_sequencer_if.slave bus
);

  localparam int TW = ADDR_W + 16;
  localparam int CW = $clog2(2 * TW);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  localparam logic [TW-1:0] FRAME_WREN = {8'h06, {(TW-8){1'b0}}};
  localparam logic [TW-1:0] FRAME_RDSR = {8'h05, {(TW-8){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    WREN,
    PROG,
    POLL,
    READ,
    RESP
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]     cnt;
  logic              gap;
  logic [GW-1:0]     gap_cnt;
  logic [PW-1:0]     poll_cnt;
  logic [TW-1:0]     tx;
  logic [7:0]        rx0;
  logic [7:0]        rx1;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [1:0]        fail_q;
  logic [7:0]        rdata_q;
  logic              err_q;

  logic              frame_active;
  logic              frame_last;
  logic              gap_done;
  logic              wip_any;
  logic              last_poll;
  logic [CW-1:0]     last_cnt;
  logic [1:0]        healthy;
  logic [1:0]        cs_targets;

  assign healthy      = ~fail_q;
  assign frame_active = !gap && (state == WREN || state == PROG || state == POLL || state == READ);
  assign frame_last   = frame_active && (cnt == last_cnt);
  assign gap_done     = gap && (gap_cnt == GW'(CS_GAP - 1));
  assign wip_any      = |(healthy & bus.spi_miso);
  assign last_poll    = (poll_cnt == PW'(POLL_MAX - 1));
  assign cs_targets   = (state == READ) ? (fail_q[0] ? 2'b01 : 2'b10) : fail_q;

  // Next-state selection and pin decode; every output is a function of registered state only.
  always_comb begin
    state_next       = state;
    last_cnt         = CW'(2 * TW - 1);
    bus.req_ready    = (state == IDLE);
    bus.busy         = (state != IDLE);
    bus.rsp_valid    = (state == RESP);
    bus.rsp_err      = (state == RESP) && err_q;
    bus.rsp_rdata    = rdata_q;
    bus.spi_cs_n     = frame_active ? cs_targets : 2'b11;
    bus.spi_sck      = frame_active && cnt[0];
    bus.spi_mosi     = frame_active && tx[TW-1];

    case (state)
      WREN:    last_cnt = CW'(15);
      POLL:    last_cnt = CW'(31);
      default: last_cnt = CW'(2 * TW - 1);
    endcase

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (&bus.disk_fail)     state_next = RESP;
          else if (bus.req_write) state_next = WREN;
          else                    state_next = READ;
        end
      end
      WREN: if (frame_last) state_next = PROG;
      PROG: if (frame_last) state_next = POLL;
      POLL: begin
        if (frame_last) begin
          if (wip_any && !last_poll) state_next = POLL;
          else                       state_next = RESP;
        end
      end
      READ:    if (frame_last) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Frame datapath: bit/gap counters, shift registers, latched request and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      gap      <= 1'b0;
      gap_cnt  <= '0;
      poll_cnt <= '0;
      tx       <= '0;
      rx0      <= '0;
      rx1      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fail_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.req_valid) begin
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        fail_q   <= bus.disk_fail;
        cnt      <= '0;
        gap      <= 1'b0;
        gap_cnt  <= '0;
        poll_cnt <= '0;
        err_q    <= &bus.disk_fail;
        tx       <= bus.req_write ? FRAME_WREN : {8'h03, bus.req_addr, 8'h00};
      end
    end else if (frame_active) begin
      cnt <= cnt + 1'b1;
      if (cnt[0]) begin
        tx  <= tx << 1;
        rx0 <= {rx0[6:0], bus.spi_miso[0]};
        rx1 <= {rx1[6:0], bus.spi_miso[1]};
      end
      if (frame_last) begin
        cnt     <= '0;
        gap     <= (state_next != RESP);
        gap_cnt <= '0;
        case (state)
          WREN: tx <= {8'h02, addr_q, wdata_q};
          PROG: tx <= FRAME_RDSR;
          POLL: begin
            tx       <= FRAME_RDSR;
            poll_cnt <= poll_cnt + 1'b1;
            err_q    <= wip_any && last_poll;
          end
          READ: rdata_q <= fail_q[0] ? {rx1[6:0], bus.spi_miso[1]} : {rx0[6:0], bus.spi_miso[0]};
          default: ;
        endcase
      end
    end else if (gap) begin
      gap_cnt <= gap_cnt + 1'b1;
      if (gap_done) gap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flash_mirror_sequencer.sv
// Scoreboard bench for flash_mirror_sequencer with a two-chip behavioural flash model.
module tb_flash_mirror_sequencer;

  localparam int ADDR_W   = 24;
  localparam int CS_GAP   = 2;
  localparam int POLL_MAX = 4;

  typedef struct {
    logic [1:0]  cs;
    int          cycles;
    logic [63:0] value;
    int          gap;
  } frame_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         latency;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  frame_t exp_frames[$];
  rsp_t   exp_rsp[$];
  int     checks = 0;
  int     errors = 0;
  int     cycle_no = 0;
  int     accept_cycle = 0;
  logic [7:0] last_rd = 8'h00;

  logic [7:0] rd_byte [2];
  int         wip_polls [2];
  bit         stuck [2];

  flash_mirror_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  flash_mirror_sequencer #(
    .ADDR_W  (ADDR_W),
    .CS_GAP  (CS_GAP),
    .POLL_MAX(POLL_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Flash chip models: decode the command byte from MOSI and shift read data or status onto MISO.
  int         idx [2] = '{0, 0};
  logic [7:0] cmd [2] = '{8'h00, 8'h00};
  int         polls_seen [2] = '{0, 0};
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (bus.spi_cs_n[c] == 1'b0) begin
        if (!bus.spi_sck) begin
          if (cmd[c] == 8'h03 && idx[c] >= 32 && idx[c] < 40)
            bus.spi_miso[c] = rd_byte[c][39 - idx[c]];
          else if (cmd[c] == 8'h05 && idx[c] == 15)
            bus.spi_miso[c] = stuck[c] || (polls_seen[c] < wip_polls[c]);
          else
            bus.spi_miso[c] = 1'b0;
        end else begin
          if (idx[c] < 8) cmd[c] = {cmd[c][6:0], bus.spi_mosi};
          idx[c]++;
        end
      end else begin
        if (idx[c] >= 8 && cmd[c] == 8'h05) polls_seen[c]++;
        if (idx[c] >= 8 && cmd[c] == 8'h06) polls_seen[c] = 0;
        idx[c] = 0;
        cmd[c] = 8'h00;
        bus.spi_miso[c] = 1'b0;
      end
    end
  end

  // SPI monitor: assemble each cs_n-low window into a frame and score it against the queue.
  bit          in_frame = 0;
  logic [1:0]  cur_cs = 2'b11;
  int          fcyc = 0;
  int          gapc = 1000;
  int          frame_gap = 0;
  logic [63:0] fbits = '0;
  bit          cs_glitch = 0;
  bit          idle_bad = 0;
  always @(negedge clk) begin
    if (bus.spi_cs_n != 2'b11) begin
      if (!in_frame) begin
        in_frame  = 1;
        cur_cs    = bus.spi_cs_n;
        fcyc      = 0;
        fbits     = '0;
        cs_glitch = 0;
        frame_gap = gapc;
      end
      if (bus.spi_cs_n != cur_cs) cs_glitch = 1;
      fcyc++;
      if (bus.spi_sck) fbits = {fbits[62:0], bus.spi_mosi};
    end else begin
      if (bus.spi_mosi !== 1'b0 || bus.spi_sck !== 1'b0) idle_bad = 1;
      if (in_frame) begin
        in_frame = 0;
        gapc = 1;
        if (exp_frames.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame: got cs=%b len=%0d bits=0x%0h expected no frame", cur_cs, fcyc, fbits);
        end else begin
          frame_t f;
          f = exp_frames.pop_front();
          checkOutput("frame_cs", 64'(cur_cs), 64'(f.cs));
          checkOutput("frame_len", 64'(fcyc), 64'(f.cycles));
          checkOutput("frame_bits", fbits, f.value);
          checkOutput("frame_cs_stable", 64'(cs_glitch), 64'd0);
          if (f.gap > 0) checkOutput("frame_gap", 64'(frame_gap), 64'(f.gap));
        end
      end else if (gapc < 1000) begin
        gapc++;
      end
    end
  end

  // Response monitor: pop the scoreboard on every rsp_valid and confirm IDLE follows.
  bit chk_ready = 0;
  always @(negedge clk) begin
    if (chk_ready) begin
      checkOutput("ready_after_rsp", 64'(bus.req_ready), 64'd1);
      chk_ready = 0;
    end
    if (bus.rsp_valid === 1'b1) begin
      chk_ready = 1;
      if (exp_rsp.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 expected no response");
      end else begin
        rsp_t r;
        r = exp_rsp.pop_front();
        checkOutput("rsp_err", 64'(bus.rsp_err), 64'(r.err));
        checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(r.rdata));
        checkOutput("rsp_latency", 64'(cycle_no - accept_cycle), 64'(r.latency));
      end
    end
  end

  task automatic pushFrame(input logic [1:0] cs, input int cycles, input logic [63:0] value, input int gap);
    frame_t f;
    f.cs = cs;
    f.cycles = cycles;
    f.value = value;
    f.gap = gap;
    exp_frames.push_back(f);
  endtask

  task automatic pushRsp(input logic [7:0] rdata, input logic err, input int latency);
    rsp_t r;
    r.rdata = rdata;
    r.err = err;
    r.latency = latency;
    exp_rsp.push_back(r);
  endtask

  task automatic expectWrite(input logic [1:0] cs, input logic [23:0] addr, input logic [7:0] wdata,
                             input int npolls, input logic err);
    pushFrame(cs, 16, 64'h06, 0);
    pushFrame(cs, 80, {24'h0, 8'h02, addr, wdata}, CS_GAP);
    for (int p = 0; p < npolls; p++) pushFrame(cs, 32, 64'h0500, CS_GAP);
    pushRsp(last_rd, err, 99 + 34 * npolls);
  endtask

  task automatic applyStimulus(input logic write, input logic [23:0] addr, input logic [7:0] wdata,
                               input logic [1:0] fail);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_ready_wait: got req_ready=0 expected 1 within 500 cycles");
    end
    bus.req_valid = 1'b1;
    bus.req_write = write;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.disk_fail = fail;
    accept_cycle  = cycle_no;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.req_ready && exp_rsp.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_rsp.size() != 0 || !bus.req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL completion_wait: got pending=%0d expected 0 within 2000 cycles", exp_rsp.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.disk_fail = 2'b00;
    rd_byte[0] = 8'hA5;
    rd_byte[1] = 8'h3C;
    wip_polls[0] = 0;
    wip_polls[1] = 0;
    stuck[0] = 0;
    stuck[1] = 0;

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 64'(bus.req_ready), 64'd1);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_cs_n", 64'(bus.spi_cs_n), 64'b11);
    checkOutput("reset_sck", 64'(bus.spi_sck), 64'd0);
    checkOutput("reset_mosi", 64'(bus.spi_mosi), 64'd0);
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    checkOutput("reset_rdata", 64'(bus.rsp_rdata), 64'd0);
    rst_n = 1'b1;

    $display("[TB] read from chip 0");
    pushFrame(2'b10, 80, 64'h03_012345_00, 0);
    pushRsp(8'hA5, 1'b0, 81);
    applyStimulus(1'b0, 24'h012345, 8'h00, 2'b00);
    waitDone();
    last_rd = 8'hA5;

    $display("[TB] read redirected to chip 1, disk_fail wiggles mid-frame");
    pushFrame(2'b01, 80, 64'h03_00ABCD_00, 0);
    pushRsp(8'h3C, 1'b0, 81);
    applyStimulus(1'b0, 24'h00ABCD, 8'h00, 2'b01);
    repeat (10) @(negedge clk);
    bus.disk_fail = 2'b00;
    repeat (10) @(negedge clk);
    bus.disk_fail = 2'b10;
    waitDone();
    last_rd = 8'h3C;

    $display("[TB] read top address with chip 1 failed");
    rd_byte[0] = 8'h96;
    pushFrame(2'b10, 80, 64'h03_FFFFFF_00, 0);
    pushRsp(8'h96, 1'b0, 81);
    applyStimulus(1'b0, 24'hFFFFFF, 8'h00, 2'b10);
    waitDone();
    last_rd = 8'h96;

    $display("[TB] mirrored write, three busy polls");
    wip_polls[0] = 3;
    wip_polls[1] = 3;
    expectWrite(2'b00, 24'h000010, 8'h5A, 4, 1'b0);
    applyStimulus(1'b1, 24'h000010, 8'h5A, 2'b00);
    waitDone();

    $display("[TB] mirrored write, chip 1 stuck busy");
    wip_polls[0] = 1;
    wip_polls[1] = 0;
    stuck[1] = 1;
    expectWrite(2'b00, 24'h800001, 8'hC3, 4, 1'b1);
    applyStimulus(1'b1, 24'h800001, 8'hC3, 2'b00);
    waitDone();

    $display("[TB] write with stuck chip 1 marked failed");
    wip_polls[0] = 0;
    expectWrite(2'b10, 24'h000100, 8'h7E, 1, 1'b0);
    applyStimulus(1'b1, 24'h000100, 8'h7E, 2'b10);
    waitDone();
    stuck[1] = 0;

    $display("[TB] both chips failed");
    pushRsp(last_rd, 1'b1, 1);
    applyStimulus(1'b0, 24'h000200, 8'h00, 2'b11);
    waitDone();
    pushRsp(last_rd, 1'b1, 1);
    applyStimulus(1'b1, 24'h000200, 8'h44, 2'b11);
    waitDone();

    $display("[TB] reset during page program");
    pushFrame(2'b00, 16, 64'h06, 0);
    pushFrame(2'b00, 12, 64'h0, CS_GAP);
    applyStimulus(1'b1, 24'h000020, 8'h11, 2'b00);
    do @(negedge clk); while (cycle_no != accept_cycle + 30);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_cs_n", 64'(bus.spi_cs_n), 64'b11);
    checkOutput("post_reset_sck", 64'(bus.spi_sck), 64'd0);
    checkOutput("post_reset_ready", 64'(bus.req_ready), 64'd1);
    checkOutput("post_reset_rdata", 64'(bus.rsp_rdata), 64'd0);
    last_rd = 8'h00;

    $display("[TB] read after reset");
    rd_byte[0] = 8'h81;
    pushFrame(2'b10, 80, 64'h03_000001_00, 0);
    pushRsp(8'h81, 1'b0, 81);
    applyStimulus(1'b0, 24'h000001, 8'h00, 2'b00);
    waitDone();

    repeat (4) @(negedge clk);
    checkOutput("frames_left", 64'(exp_frames.size()), 64'd0);
    checkOutput("rsp_left", 64'(exp_rsp.size()), 64'd0);
    checkOutput("idle_lines", 64'(idle_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
